// File: rtl/nes_rom_loader.sv
// rtl/nes_rom_loader.sv - iNES / NES 2.0 image loader streaming trainer, PRG and CHR bytes into memory
// Trainer loading is compiled in only when NES_LOADER_TRAINER_EN is defined.
module nes_rom_loader #(
  parameter int                ADDR_W   = 22,
  parameter logic [ADDR_W-1:0] CHR_BASE = 22'h200000,
  parameter logic [ADDR_W-1:0] TRN_BASE = 22'h3FFE00
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              invert_mirroring,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_data,
  output logic              mem_wr,
  input  logic              mem_ready,
  output logic [31:0]       mapper_flags,
  output logic              done,
  output logic              error,
  output logic [1:0]        err_code
);

  localparam int CW = (ADDR_W > 26) ? ADDR_W : 26;
`ifdef NES_LOADER_TRAINER_EN
  localparam logic TRN_OK = 1'b1;
`else
  localparam logic TRN_OK = 1'b0;
`endif

  // S_DRAIN waits for the final write handshake before DONE
  typedef enum logic [2:0] {
    S_HDR, S_TRN, S_PRG, S_CHR, S_DRAIN, S_DONE, S_ERR
  } state_t;

  state_t            state, state_nx;
  logic [7:0]        ines [16];
  logic [3:0]        hdr_cnt;
  logic [CW-1:0]     off;
  logic              active;
  logic [1:0]        err_nx;
  logic              accept, region;
  logic              nes2, magic_ok, exp_form, dirty;
  logic [11:0]       prg_units, chr_units;
  logic [CW-1:0]     prg_len, chr_len;
  logic [7:0]        hdr15;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       flags_nx;

  function automatic logic [2:0] log2_sat(input logic [11:0] u);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 1; i < 8; i++)
      if (u >= (12'd1 << i)) r = 3'(i);
    return r;
  endfunction

  always_comb begin
    nes2      = (ines[7][3:2] == 2'b10);
    prg_units = nes2 ? {ines[9][3:0], ines[4]} : {4'h0, ines[4]};
    chr_units = nes2 ? {ines[9][7:4], ines[5]} : {4'h0, ines[5]};
    prg_len   = CW'({prg_units, 14'd0});
    chr_len   = CW'({chr_units, 13'd0});
    magic_ok  = (ines[0] == 8'h4E) && (ines[1] == 8'h45) && (ines[2] == 8'h53) && (ines[3] == 8'h1A);
    exp_form  = nes2 && ((ines[9][3:0] == 4'hF) || (ines[9][7:4] == 4'hF));
    // byte 15 is still on the input when an empty image goes straight to DONE
    hdr15     = (state == S_HDR) ? in_data : ines[15];
    dirty     = !nes2 && ((ines[8] | ines[9] | ines[10] | ines[11] | ines[12] |
                           ines[13] | ines[14] | hdr15) != 8'h00);
    flags_nx  = {7'd0,
                 nes2 ? ines[8][3:0] : 4'h0,
                 nes2 ? ines[8][7:4] : 4'h0,
                 ines[6][3],
                 ~|chr_units,
                 ines[6][0] ^ invert_mirroring,
                 log2_sat(chr_units),
                 log2_sat(prg_units),
                 dirty ? 4'h0 : ines[7][7:4],
                 ines[6][7:4]};
  end

  always_comb begin
    case (state)
      S_TRN:   wr_addr = TRN_BASE + ADDR_W'(off[8:0]);
      S_CHR:   wr_addr = CHR_BASE + off[ADDR_W-1:0];
      default: wr_addr = off[ADDR_W-1:0];
    endcase
  end

  always_comb begin
    state_nx = state;
    err_nx   = 2'd0;
    in_ready = 1'b0;
    if (active) begin
      case (state)
        S_DONE, S_ERR: in_ready = 1'b1;
        S_DRAIN:       in_ready = 1'b0;
        default:       in_ready = !(mem_wr && !mem_ready);
      endcase
    end
    accept = in_valid && in_ready;
    region = (state == S_TRN) || (state == S_PRG) || (state == S_CHR);
    case (state)
      S_HDR: if (accept && (hdr_cnt == 4'd15)) begin
        if (!magic_ok) begin
          state_nx = S_ERR;
          err_nx   = 2'd1;
        end else if (exp_form || (ines[6][2] && !TRN_OK)) begin
          state_nx = S_ERR;
          err_nx   = 2'd2;
        end else if (prg_len > CW'(CHR_BASE)) begin
          state_nx = S_ERR;
          err_nx   = 2'd3;
`ifdef NES_LOADER_TRAINER_EN
        end else if (ines[6][2]) begin
          state_nx = S_TRN;
`endif
        end else if (|prg_units) begin
          state_nx = S_PRG;
        end else if (|chr_units) begin
          state_nx = S_CHR;
        end else begin
          state_nx = S_DONE;
        end
      end
`ifdef NES_LOADER_TRAINER_EN
      S_TRN: if (accept && (off == CW'(511))) begin
        if (|prg_units)      state_nx = S_PRG;
        else if (|chr_units) state_nx = S_CHR;
        else                 state_nx = S_DRAIN;
      end
`endif
      S_PRG: if (accept && (off == prg_len - 1'b1))
        state_nx = (|chr_units) ? S_CHR : S_DRAIN;
      S_CHR: if (accept && (off == chr_len - 1'b1))
        state_nx = S_DRAIN;
      S_DRAIN: if (!mem_wr || mem_ready)
        state_nx = S_DONE;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_HDR;
    else          state <= state_nx;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      active       <= 1'b0;
      hdr_cnt      <= 4'd0;
      off          <= '0;
      mem_wr       <= 1'b0;
      mem_addr     <= '0;
      mem_data     <= 8'h00;
      mapper_flags <= 32'd0;
      done         <= 1'b0;
      error        <= 1'b0;
      err_code     <= 2'd0;
      for (int i = 0; i < 16; i++) ines[i] <= 8'h00;
    end else begin
      active <= 1'b1;
      if ((state == S_HDR) && accept) begin
        ines[hdr_cnt] <= in_data;
        hdr_cnt       <= hdr_cnt + 4'd1;
      end
      if (state_nx != state)    off <= '0;
      else if (region && accept) off <= off + 1'b1;
      // a fresh accept reloads the write slot in the same cycle the old one completes
      if (region && accept) begin
        mem_wr   <= 1'b1;
        mem_addr <= wr_addr;
        mem_data <= in_data;
      end else if (mem_ready) begin
        mem_wr <= 1'b0;
      end
      if ((state_nx == S_DONE) && (state != S_DONE)) begin
        done         <= 1'b1;
        mapper_flags <= flags_nx;
      end
      if ((state_nx == S_ERR) && (state != S_ERR)) begin
        done     <= 1'b1;
        error    <= 1'b1;
        err_code <= err_nx;
      end
    end
  end

endmodule

// File: tb/tb_nes_rom_loader.sv
// tb/tb_nes_rom_loader.sv - randomized self-checking bench for nes_rom_loader
// Expected writes and flags come from a header-level model of the image format.
module tb_nes_rom_loader;

  localparam logic [21:0] CHRB = 22'h200000;
  localparam logic [21:0] TRNB = 22'h3FFE00;
`ifdef NES_LOADER_TRAINER_EN
  localparam bit TRN_EN = 1'b1;
`else
  localparam bit TRN_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        invert_mirroring;
  logic [21:0] mem_addr;
  logic [7:0]  mem_data;
  logic        mem_wr;
  logic        mem_ready;
  logic [31:0] mapper_flags;
  logic        done;
  logic        error;
  logic [1:0]  err_code;

  always #5 clk = ~clk;

  nes_rom_loader #(.ADDR_W(22), .CHR_BASE(CHRB), .TRN_BASE(TRNB)) dut (
    .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .invert_mirroring(invert_mirroring), .mem_addr(mem_addr),
    .mem_data(mem_data), .mem_wr(mem_wr), .mem_ready(mem_ready),
    .mapper_flags(mapper_flags), .done(done), .error(error), .err_code(err_code)
  );

  typedef struct { int addr; int data; } wr_t;

  int          hdr [16];
  int          img [$];
  wr_t         exp_q [$];
  int          exp_code;
  logic [31:0] exp_flags;
  int          n_vec = 0;
  int          n_err = 0;

  function automatic int lg(input int u);
    int r = 0;
    while (r < 7 && (2 << r) <= u) r++;
    return r;
  endfunction

  function automatic void build_model();
    bit nes2, dirty;
    int pu, cu, p, f, mlo;
    exp_q.delete();
    nes2 = ((hdr[7] >> 2) & 3) == 2;
    pu = nes2 ? (hdr[9] & 15) * 256 + hdr[4] : hdr[4];
    cu = nes2 ? (hdr[9] >> 4) * 256 + hdr[5] : hdr[5];
    exp_code = 0;
    if (hdr[0] != 'h4E || hdr[1] != 'h45 || hdr[2] != 'h53 || hdr[3] != 'h1A) exp_code = 1;
    else if ((nes2 && ((hdr[9] & 15) == 15 || (hdr[9] >> 4) == 15)) || ((hdr[6] & 4) != 0 && !TRN_EN)) exp_code = 2;
    else if (pu * 16384 > int'(CHRB)) exp_code = 3;
    exp_flags = 32'd0;
    if (exp_code != 0) return;
    p = 16;
    if ((hdr[6] & 4) != 0)
      for (int i = 0; i < 512 && p < img.size(); i++) begin exp_q.push_back('{int'(TRNB) + i, img[p]}); p++; end
    for (int i = 0; i < pu * 16384 && p < img.size(); i++) begin exp_q.push_back('{i, img[p]}); p++; end
    for (int i = 0; i < cu * 8192 && p < img.size(); i++) begin exp_q.push_back('{int'(CHRB) + i, img[p]}); p++; end
    dirty = 1'b0;
    for (int i = 8; i < 16; i++) if (!nes2 && hdr[i] != 0) dirty = 1'b1;
    mlo = dirty ? (hdr[6] >> 4) : ((hdr[7] & 'hF0) | (hdr[6] >> 4));
    f = mlo | (lg(pu) << 8) | (lg(cu) << 11) | (((hdr[6] & 1) ^ int'(invert_mirroring)) << 14)
        | ((cu == 0 ? 1 : 0) << 15) | (((hdr[6] >> 3) & 1) << 16)
        | ((nes2 ? (hdr[8] >> 4) : 0) << 17) | ((nes2 ? (hdr[8] & 15) : 0) << 21);
    exp_flags = 32'(f);
  endfunction

  task automatic new_header();
    for (int i = 0; i < 16; i++) hdr[i] = 0;
    hdr[0] = 'h4E; hdr[1] = 'h45; hdr[2] = 'h53; hdr[3] = 'h1A;
    hdr[6] = $urandom_range(0, 255) & 'hFB;
    hdr[7] = $urandom_range(0, 255) & 'hF3;
  endtask

  task automatic make_image(input int payload);
    img.delete();
    for (int i = 0; i < 16; i++) img.push_back(hdr[i]);
    for (int i = 0; i < payload; i++) img.push_back($urandom_range(0, 255));
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0; in_valid = 1'b0; mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  // streams img into the DUT and checks every completed write against exp_q
  task automatic play(input bit stall, input int max_cyc, input bit expect_done);
    int idx = 0;
    int cyc = 0;
    bit prev_stall = 1'b0;
    logic [21:0] pa = '0;
    logic [7:0]  pd = '0;
    wr_t w;
    forever begin
      @(negedge clk);
      in_valid  = (idx < img.size()) && (!stall || $urandom_range(0, 3) != 0);
      in_data   = (idx < img.size()) ? 8'(img[idx]) : 8'h00;
      mem_ready = stall ? (cyc % 3 == 2) : 1'b1;
      #1;
      if (done === 1'b1) break;
      if (cyc >= max_cyc) begin
        if (expect_done) begin
          n_vec++; n_err++;
          $display("FAIL timeout: done=%0b after %0d cycles, want 1", done, cyc);
        end
        break;
      end
      if (prev_stall) begin
        n_vec++;
        if (mem_wr !== 1'b1 || mem_addr !== pa || mem_data !== pd) begin
          n_err++;
          $display("FAIL stall_hold: wr=%0b addr=%h data=%h, want wr=1 addr=%h data=%h", mem_wr, mem_addr, mem_data, pa, pd);
        end
      end
      if (mem_wr === 1'b1 && !mem_ready) begin
        n_vec++;
        if (in_ready !== 1'b0) begin n_err++; $display("FAIL stall_ready: in_ready=%0b, want 0", in_ready); end
      end
      if (mem_wr === 1'b1 && mem_ready) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL extra_write: addr=%h data=%h, want no write", mem_addr, mem_data);
        end else begin
          w = exp_q.pop_front();
          if (mem_addr !== 22'(w.addr) || mem_data !== 8'(w.data)) begin
            n_err++;
            $display("FAIL write: addr=%h data=%h, want addr=%h data=%h", mem_addr, mem_data, 22'(w.addr), 8'(w.data));
          end
        end
      end
      prev_stall = (mem_wr === 1'b1) && !mem_ready;
      pa = mem_addr; pd = mem_data;
      if (in_valid && in_ready) idx++;
      cyc++;
    end
    in_valid = 1'b0;
    if (expect_done) begin
      n_vec++;
      if (exp_q.size() != 0) begin n_err++; $display("FAIL missing_writes: %0d pending, want 0", exp_q.size()); end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; in_valid = 1'b1; in_data = 8'($urandom); mem_ready = 1'($urandom); invert_mirroring = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    n_vec++;
    if ({mem_wr, mem_addr, mem_data, mapper_flags, done, error, err_code, in_ready} !== '0) begin
      n_err++;
      $display("FAIL reset_values: wr=%0b addr=%h data=%h flags=%h done=%0b err=%0b code=%0d rdy=%0b, want all 0",
               mem_wr, mem_addr, mem_data, mapper_flags, done, error, err_code, in_ready);
    end
    in_valid = 1'b0;
    reset_n = 1'b1;
    #1;
    n_vec++;
    if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_exit_early: in_ready=%0b, want 0", in_ready); end
    @(negedge clk); #1;
    n_vec++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_exit: in_ready=%0b, want 1", in_ready); end
  endtask

  task automatic test_ines1_full();
    do_reset();
    new_header();
    hdr[4] = 2; hdr[5] = 1;
    if ($urandom_range(0, 1) == 1) for (int i = 8; i < 16; i++) hdr[i] = $urandom_range(0, 255);
    invert_mirroring = 1'($urandom);
    make_image(32768 + 8192);
    build_model();
    play(1'b0, 45000, 1'b1);
    n_vec++;
    if ({done, error, err_code} !== 4'b1000) begin n_err++; $display("FAIL full_status: done=%0b err=%0b code=%0d, want 1 0 0", done, error, err_code); end
    n_vec++;
    if (mapper_flags !== exp_flags) begin n_err++; $display("FAIL full_flags: %h, want %h", mapper_flags, exp_flags); end
    n_vec++;
    if (mapper_flags[13:8] !== 6'b000001) begin n_err++; $display("FAIL full_sizes: %b, want 000001", mapper_flags[13:8]); end
    n_vec++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL done_ready: in_ready=%0b, want 1", in_ready); end
  endtask

  task automatic test_bad_magic();
    do_reset();
    new_header();
    hdr[3] = 'h00;
    make_image(32);
    build_model();
    play(1'b0, 200, 1'b1);
    n_vec++;
    if ({done, error, err_code} !== 4'b1101) begin n_err++; $display("FAIL magic_status: done=%0b err=%0b code=%0d, want 1 1 1", done, error, err_code); end
    n_vec++;
    if (in_ready !== 1'b1 || mapper_flags !== 32'd0) begin n_err++; $display("FAIL magic_ready: in_ready=%0b flags=%h, want 1 0", in_ready, mapper_flags); end
  endtask

  task automatic test_size_errors();
    for (int k = 0; k < 4; k++) begin
      do_reset();
      new_header();
      case (k)
        0: begin hdr[7] = hdr[7] | 'h08; hdr[9] = 'h01; hdr[4] = 0; end
        1: hdr[4] = 129;
        2: begin hdr[7] = hdr[7] | 'h08; hdr[9] = 'hF0; end
        default: begin hdr[7] = hdr[7] | 'h08; hdr[9] = 'h0F; end
      endcase
      make_image(32);
      build_model();
      play(1'b0, 200, 1'b1);
      n_vec++;
      if ({done, error, err_code} !== {2'b11, 2'(exp_code)}) begin
        n_err++;
        $display("FAIL size_err%0d: done=%0b err=%0b code=%0d, want 1 1 %0d", k, done, error, err_code, exp_code);
      end
    end
    do_reset();
    new_header();
    hdr[4] = 128; hdr[5] = 0;
    make_image(64);
    build_model();
    play(1'b0, 60, 1'b0);
    n_vec++;
    if (error !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL prg_at_limit: done=%0b err=%0b, want 0 0", done, error); end
  endtask

  task automatic test_trainer();
    do_reset();
    new_header();
    hdr[4] = 1; hdr[5] = 0;
    hdr[6] = hdr[6] | 4;
    make_image(TRN_EN ? 512 + 16384 : 32);
    build_model();
    play(1'b0, 20000, 1'b1);
    n_vec++;
    if ({done, error, err_code} !== {1'b1, exp_code != 0, 2'(exp_code)}) begin
      n_err++;
      $display("FAIL trainer_status: done=%0b err=%0b code=%0d, want 1 %0b %0d", done, error, err_code, exp_code != 0, exp_code);
    end
    n_vec++;
    if (mapper_flags !== exp_flags) begin n_err++; $display("FAIL trainer_flags: %h, want %h", mapper_flags, exp_flags); end
  endtask

  task automatic test_mid_reset();
    do_reset();
    new_header();
    hdr[4] = 1; hdr[5] = 0;
    make_image(16384);
    build_model();
    play(1'b0, $urandom_range(40, 300), 1'b0);
    n_vec++;
    if (mem_wr !== 1'b1) begin n_err++; $display("FAIL midload_pending: mem_wr=%0b, want 1", mem_wr); end
    #2 reset_n = 1'b0;
    #1;
    n_vec++;
    if ({mem_wr, mem_addr, mem_data, mapper_flags, done, error, err_code, in_ready} !== '0) begin
      n_err++;
      $display("FAIL async_reset: wr=%0b addr=%h data=%h flags=%h done=%0b err=%0b code=%0d rdy=%0b, want all 0",
               mem_wr, mem_addr, mem_data, mapper_flags, done, error, err_code, in_ready);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_stall();
    new_header();
    hdr[7] = (hdr[7] & 'hF3) | 'h08;
    hdr[4] = 0; hdr[5] = 1; hdr[9] = 0;
    hdr[8] = $urandom_range(0, 255);
    invert_mirroring = 1'($urandom);
    make_image(8192);
    build_model();
    play(1'b1, 45000, 1'b1);
    n_vec++;
    if ({done, error, err_code} !== 4'b1000) begin n_err++; $display("FAIL stall_status: done=%0b err=%0b code=%0d, want 1 0 0", done, error, err_code); end
    n_vec++;
    if (mapper_flags !== exp_flags) begin n_err++; $display("FAIL stall_flags: %h, want %h", mapper_flags, exp_flags); end
  endtask

  initial begin
    in_data = 8'h00; in_valid = 1'b0; mem_ready = 1'b1; invert_mirroring = 1'b0;
    test_reset();
    test_ines1_full();
    test_bad_magic();
    test_size_errors();
    test_trainer();
    test_mid_reset();
    test_stall();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
